tetris_playfield_ctrl: RTL and testbench
========================================

# tetris_playfield_ctrl

Parametrised successor to the single-grid Tetris game FSM. It owns the stored playfield for a grid of configurable size and the active falling piece. It supports per-piece 4x4 masks, rotation, left/right moves, hard drop and full-row clearing with a line counter. Everything runs in one clock domain: gravity arrives as a single-cycle strobe, not a second clock. It sits between the piece generator (valid/ready) and the VGA/display renderer.

## Interface
- `COLS`, 10, grid width; packed bit `COLS-1` is the leftmost column.
- `ROWS`, 20, grid height; row 0 is the top.
- `SPAWN_COL`, 5, bit index of the 4x4 box's leftmost column at spawn.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `start_i`  in  1  strobe that starts a new game from IDLE or GAMEOVER.
- `gravity_tick_i`  in  1  single-cycle fall strobe.
- `left_i`, `right_i`, `rotate_i`, `drop_i`  in  1  single-cycle, already-debounced move strobes.
- `piece_valid_i`  in  1  generator has a piece.
- `piece_type_i`  in  3  0 I, 1 O, 2 L, 3 J, 4 S, 5 Z, 6 T; 7 is treated as I.
- `piece_req_o`  out  1  ready; high only in REQ.
- `display_o`  out  ROWS*COLS  packed `[ROWS-1:0][COLS-1:0]`, stored grid OR the active piece.
- `lines_clr_valid_o`  out  1  one-cycle pulse at the end of each clear scan.
- `lines_clr_o`  out  3  rows cleared by the last lock (0..4); valid with the pulse.
- `lines_total_o`  out  16  saturating count of cleared rows.
- `game_over_o`  out  1  high in GAMEOVER.

## Operation
- **Piece geometry**
  - Position is (row, col); `col` is signed, `$clog2(COLS)+2` bits wide.
  - Mask cell (i,j), with i down and j right, occupies grid row `row+i`, bit `col-j`.
  - Rotation-0 masks, 4 rows each, j=0..3 left to right: I 0100/0100/0100/0100; O 1100/1100; L 1000/1000/1100; J 0100/0100/1100; S 0110/1100; Z 1100/0110; T 0100/1110.
  - Clockwise rotation: `new(i,j)=old(3-j,i)`, applied `rot` (2-bit) times.
  - Rotation is ignored for O.
- **fits(row,col,rot)**: every set cell has grid row < ROWS, bit in 0..COLS-1, and no stored cell already set.
- **State machine**
  - IDLE: `start_i` clears grid and `lines_total_o`, then goes to REQ.
  - REQ: `piece_req_o`=1; on `piece_valid_i`&`piece_req_o`, capture the type, set row=0, col=SPAWN_COL, rot=0, go to SPAWN.
  - SPAWN: if fits, go to FALL; else go to GAMEOVER. The failed piece is not merged or displayed.
  - FALL: one action per cycle, priority `drop_i` > `gravity_tick_i` > `rotate_i` > `left_i` > `right_i`. Lower-priority simultaneous strobes are discarded.
    - Tick: move down one row if it fits, else go to LOCK.
    - Rotate, left (col+1) or right (col-1): apply only if the result fits, else no change.
    - Drop: go to DROP.
  - DROP: ignores all move inputs. Each cycle, move down one row if it fits, else go to LOCK.
  - LOCK: OR the piece cells into the grid (1 cycle). Set the scan row to ROWS-1, clear the line counter, go to CLEAR.
  - CLEAR: one row per cycle.
    - If the scan row is full: rows r..1 take r-1, row 0 is zeroed, the count increments, and the same r is rescanned.
    - Else decrement r.
    - After row 0 is evaluated not-full: pulse `lines_clr_valid_o` with the count, add the count to `lines_total_o` (saturating at 16'hFFFF), go to REQ.
  - GAMEOVER: `game_over_o`=1. `start_i` clears the grid and total, then goes to REQ.
- **Display**: the active piece is ORed into `display_o` only in FALL and DROP.

## Timing
- **Reset**: while `reset_n`=0 at a clock edge, state goes to IDLE and every output is 0 (grid, total, pulses, request, game_over). Reset mid-clear or mid-drop abandons the operation; no partial merge persists.
- **Outputs**: all registered state; `display_o` is combinational from registers. A strobe sampled at edge N is visible on `display_o` after edge N.
- **Handshake to FALL**: transfer at edge N, SPAWN at N, FALL after N+1. The piece appears on `display_o` after N+1.
- **Lock path**:
  - The blocked tick moves to LOCK.
  - LOCK takes 1 cycle.
  - CLEAR takes ROWS + (cleared rows) cycles, with `lines_clr_valid_o` on the last one.
  - REQ follows on the next cycle.
- **Drop**: takes one cycle per row descended, plus one cycle to detect the block.
- **Gravity in CLEAR**: `gravity_tick_i` arriving during REQ, SPAWN, LOCK or CLEAR is dropped (not queued).

## Test plan
- **Reset and spawn**: hold `reset_n`=0 for 2 cycles → all outputs 0. Pulse `start_i`, then `piece_req_o`=1. Present type 1 (O) → 2 cycles later rows 0,1 bits 5,4 are set.
- **Gravity lock**: O piece with 18 ticks → rows 18,19. The 19th tick → LOCK, then 20 CLEAR cycles, then `lines_clr_valid_o`=1 with `lines_clr_o`=0, then `piece_req_o`=1.
- **Wall and priority**:
  - I piece occupies bit 4. Five `left_i` → bit 9; the sixth leaves it unchanged.
  - `gravity_tick_i` and `left_i` in the same cycle → down one row, column unchanged.
- **Rotation**: spawn I, pulse `rotate_i` → row 1 bits 5..2 set. Rotate adjacent to the wall where the result would not fit → no change.
- **Line clear**: ten I pieces hard-dropped, one per column → `lines_clr_o`=4, display empty, `lines_total_o`=4.
- **Game over and restart**:
  - Eleven O pieces hard-dropped without moving → the 11th spawn fails, `game_over_o`=1, `piece_req_o`=0.
  - `start_i` → grid 0, `lines_total_o`=0, `piece_req_o`=1.
  - `reset_n` low mid-DROP → IDLE, display 0.

Source files
------------

// File: rtl/tetris_playfield_ctrl.sv
// Tetris playfield controller: stored grid, active 4x4 piece, moves/rotation/drop,
// full-row clearing and a saturating cleared-line total, all in one clock domain.
module tetris_playfield_ctrl #(
  parameter int unsigned COLS      = 10,
  parameter int unsigned ROWS      = 20,
  parameter int unsigned SPAWN_COL = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_i,
  input  logic                       gravity_tick_i,
  input  logic                       left_i,
  input  logic                       right_i,
  input  logic                       rotate_i,
  input  logic                       drop_i,
  input  logic                       piece_valid_i,
  input  logic [2:0]                 piece_type_i,
  output logic                       piece_req_o,
  output logic [ROWS-1:0][COLS-1:0]  display_o,
  output logic                       lines_clr_valid_o,
  output logic [2:0]                 lines_clr_o,
  output logic [15:0]                lines_total_o,
  output logic                       game_over_o
);

  localparam int CW     = $clog2(COLS) + 2;
  localparam int RW     = $clog2(ROWS + 4);
  localparam int RIW    = $clog2(ROWS);
  localparam int CIW    = $clog2(COLS);
  localparam int RowsI  = ROWS;
  localparam int ColsI  = COLS;
  localparam logic signed [CW-1:0] ColOne = 1;

  // Cell (i,j) of a mask lives at m[i][3-j]: row nibble written left to right.
  typedef logic [3:0][3:0] mask_t;
  typedef enum logic [2:0] {
    StIdle, StReq, StSpawn, StFall, StDrop, StLock, StClear, StGameover
  } state_t;

  state_t                     r_state;
  logic [ROWS-1:0][COLS-1:0]  r_grid;
  logic [2:0]                 r_type;
  logic [RW-1:0]              r_row;
  logic signed [CW-1:0]       r_col;
  logic [1:0]                 r_rot;
  logic [RIW-1:0]             r_scan;
  logic [2:0]                 r_cnt;
  logic                       r_clr_valid;
  logic [2:0]                 r_clr;
  logic [15:0]                r_total;
  logic                       r_req;
  logic                       r_game_over;

  logic [RW-1:0]              w_cand_row;
  logic signed [CW-1:0]       w_cand_col;
  logic [1:0]                 w_cand_rot;
  mask_t                      w_cand_mask;
  mask_t                      w_cur_mask;
  logic                       w_fits;
  logic [ROWS-1:0][COLS-1:0]  w_piece;
  logic [16:0]                w_total_sum;

  function automatic mask_t base_mask(input logic [2:0] t);
    mask_t m;
    unique case (t)
      3'd1:    m = {4'b0000, 4'b0000, 4'b1100, 4'b1100};
      3'd2:    m = {4'b0000, 4'b1100, 4'b1000, 4'b1000};
      3'd3:    m = {4'b0000, 4'b1100, 4'b0100, 4'b0100};
      3'd4:    m = {4'b0000, 4'b0000, 4'b1100, 4'b0110};
      3'd5:    m = {4'b0000, 4'b0000, 4'b0110, 4'b1100};
      3'd6:    m = {4'b0000, 4'b0000, 4'b1110, 4'b0100};
      default: m = {4'b0100, 4'b0100, 4'b0100, 4'b0100};
    endcase
    return m;
  endfunction

  // Clockwise: new(i,j) = old(3-j,i).
  function automatic mask_t rot_cw(input mask_t m);
    mask_t r;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r[i][3-j] = m[3-j][3-i];
      end
    end
    return r;
  endfunction

  function automatic mask_t piece_mask(input logic [2:0] t, input logic [1:0] rot);
    mask_t m;
    m = base_mask(t);
    if (t != 3'd1) begin
      for (int k = 0; k < 3; k++) begin
        if (k < int'(rot)) m = rot_cw(m);
      end
    end
    return m;
  endfunction

  // One candidate position per cycle, chosen by the same priority the FSM applies.
  always_comb begin
    w_cand_row = r_row;
    w_cand_col = r_col;
    w_cand_rot = r_rot;
    case (r_state)
      StFall: begin
        if (!drop_i) begin
          if (gravity_tick_i)  w_cand_row = r_row + 1'b1;
          else if (rotate_i)   w_cand_rot = r_rot + 2'd1;
          else if (left_i)     w_cand_col = r_col + ColOne;
          else if (right_i)    w_cand_col = r_col - ColOne;
        end
      end
      StDrop:  w_cand_row = r_row + 1'b1;
      default: ;
    endcase
  end

  assign w_cand_mask = piece_mask(r_type, w_cand_rot);
  assign w_cur_mask  = piece_mask(r_type, r_rot);

  always_comb begin
    int rr;
    int cc;
    w_fits  = 1'b1;
    w_piece = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        rr = int'(w_cand_row) + i;
        cc = int'(w_cand_col) - j;
        if (w_cand_mask[i][3-j]) begin
          if (rr >= RowsI || cc < 0 || cc >= ColsI) w_fits = 1'b0;
          else if (r_grid[rr[RIW-1:0]][cc[CIW-1:0]]) w_fits = 1'b0;
        end
        rr = int'(r_row) + i;
        cc = int'(r_col) - j;
        if (w_cur_mask[i][3-j] && rr < RowsI && cc >= 0 && cc < ColsI) begin
          w_piece[rr[RIW-1:0]][cc[CIW-1:0]] = 1'b1;
        end
      end
    end
  end

  assign w_total_sum = {1'b0, r_total} + {14'b0, r_cnt};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_grid      <= '0;
      r_type      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_rot       <= '0;
      r_scan      <= '0;
      r_cnt       <= '0;
      r_clr_valid <= 1'b0;
      r_clr       <= '0;
      r_total     <= '0;
      r_req       <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_clr_valid <= 1'b0;
      case (r_state)
        StIdle, StGameover: begin
          if (start_i) begin
            r_grid      <= '0;
            r_total     <= '0;
            r_req       <= 1'b1;
            r_game_over <= 1'b0;
            r_state     <= StReq;
          end
        end
        StReq: begin
          if (piece_valid_i && r_req) begin
            r_type  <= (piece_type_i == 3'd7) ? 3'd0 : piece_type_i;
            r_row   <= '0;
            r_col   <= CW'(SPAWN_COL);
            r_rot   <= '0;
            r_req   <= 1'b0;
            r_state <= StSpawn;
          end
        end
        StSpawn: begin
          if (w_fits) begin
            r_state <= StFall;
          end else begin
            r_game_over <= 1'b1;
            r_state     <= StGameover;
          end
        end
        StFall: begin
          if (drop_i) begin
            r_state <= StDrop;
          end else if (gravity_tick_i) begin
            if (w_fits) r_row <= w_cand_row;
            else        r_state <= StLock;
          end else if ((rotate_i || left_i || right_i) && w_fits) begin
            r_rot <= w_cand_rot;
            r_col <= w_cand_col;
          end
        end
        StDrop: begin
          if (w_fits) r_row <= w_cand_row;
          else        r_state <= StLock;
        end
        StLock: begin
          r_grid  <= r_grid | w_piece;
          r_scan  <= RIW'(ROWS - 1);
          r_cnt   <= '0;
          r_state <= StClear;
        end
        StClear: begin
          // A full row collapses everything above it; the same row index is rescanned.
          if (&r_grid[r_scan]) begin
            for (int k = 1; k < RowsI; k++) begin
              if (k <= int'(r_scan)) r_grid[k] <= r_grid[k-1];
            end
            r_grid[0] <= '0;
            r_cnt     <= r_cnt + 3'd1;
          end else if (r_scan == '0) begin
            r_clr_valid <= 1'b1;
            r_clr       <= r_cnt;
            r_total     <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
            r_req       <= 1'b1;
            r_state     <= StReq;
          end else begin
            r_scan <= r_scan - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign display_o         = ((r_state == StFall) || (r_state == StDrop)) ? (r_grid | w_piece)
                                                                          : r_grid;
  assign piece_req_o       = r_req;
  assign lines_clr_valid_o = r_clr_valid;
  assign lines_clr_o       = r_clr;
  assign lines_total_o     = r_total;
  assign game_over_o       = r_game_over;

endmodule

// File: tb/tb_tetris_playfield_ctrl.sv
// Directed self-checking bench for tetris_playfield_ctrl (10x20 grid, spawn column 5).
module tb_tetris_playfield_ctrl;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  typedef logic [ROWS-1:0][COLS-1:0] grid_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic        gravity_tick_i = 1'b0;
  logic        left_i = 1'b0;
  logic        right_i = 1'b0;
  logic        rotate_i = 1'b0;
  logic        drop_i = 1'b0;
  logic        piece_valid_i = 1'b0;
  logic [2:0]  piece_type_i = 3'd0;
  logic        piece_req_o;
  grid_t       display_o;
  logic        lines_clr_valid_o;
  logic [2:0]  lines_clr_o;
  logic [15:0] lines_total_o;
  logic        game_over_o;

  int n_checks = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tetris_playfield_ctrl #(.COLS(COLS), .ROWS(ROWS), .SPAWN_COL(5)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_i           (start_i),
    .gravity_tick_i    (gravity_tick_i),
    .left_i            (left_i),
    .right_i           (right_i),
    .rotate_i          (rotate_i),
    .drop_i            (drop_i),
    .piece_valid_i     (piece_valid_i),
    .piece_type_i      (piece_type_i),
    .piece_req_o       (piece_req_o),
    .display_o         (display_o),
    .lines_clr_valid_o (lines_clr_valid_o),
    .lines_clr_o       (lines_clr_o),
    .lines_total_o     (lines_total_o),
    .game_over_o       (game_over_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic g, input logic l, input logic r, input logic rot,
                        input logic d);
    gravity_tick_i = g; left_i = l; right_i = r; rotate_i = rot; drop_i = d;
    tick();
    gravity_tick_i = 0; left_i = 0; right_i = 0; rotate_i = 0; drop_i = 0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic restart();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    pulse_start();
  endtask

  // Transfer edge, then the SPAWN edge; the piece is on display afterwards.
  task automatic give_piece(input logic [2:0] t);
    piece_valid_i = 1'b1;
    piece_type_i  = t;
    tick();
    piece_valid_i = 1'b0;
    tick();
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!piece_req_o && n < 300) begin
      tick();
      n++;
    end
    ok = piece_req_o;
  endtask

  task automatic wait_valid(output bit ok, output int n);
    n = 0;
    while (!lines_clr_valid_o && n < 300) begin
      tick();
      n++;
    end
    ok = lines_clr_valid_o;
  endtask

  task automatic test_reset();
    grid_t e;
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (display_o !== '0) begin
      n_bad++; $display("FAIL reset_display got=%h want=0", display_o);
    end
    n_checks++;
    if ({piece_req_o, lines_clr_valid_o, lines_clr_o, lines_total_o, game_over_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got req=%b v=%b clr=%0d tot=%0d go=%b want all 0",
               piece_req_o, lines_clr_valid_o, lines_clr_o, lines_total_o, game_over_o);
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (piece_req_o !== 1'b0) begin
      n_bad++; $display("FAIL idle_req got=%b want=0", piece_req_o);
    end
    pulse_start();
    n_checks++;
    if (piece_req_o !== 1'b1) begin
      n_bad++; $display("FAIL start_req got=%b want=1", piece_req_o);
    end
    piece_valid_i = 1'b1;
    piece_type_i  = 3'd1;
    tick();
    piece_valid_i = 1'b0;
    n_checks++;
    if (piece_req_o !== 1'b0 || display_o !== '0) begin
      n_bad++; $display("FAIL spawn_state got req=%b disp=%h want req=0 disp=0",
                        piece_req_o, display_o);
    end
    tick();
    e = '0;
    e[0][5] = 1; e[0][4] = 1; e[1][5] = 1; e[1][4] = 1;
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL spawn_o got=%h want=%h", display_o, e);
    end
  endtask

  task automatic test_gravity_lock();
    grid_t e;
    bit ok;
    int n;
    for (int k = 0; k < 18; k++) strobe(1, 0, 0, 0, 0);
    e = '0;
    e[18][5] = 1; e[18][4] = 1; e[19][5] = 1; e[19][4] = 1;
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL gravity_rows got=%h want=%h", display_o, e);
    end
    // Blocked tick, with gravity then held high through LOCK/CLEAR where it must be ignored.
    gravity_tick_i = 1'b1;
    tick();
    wait_valid(ok, n);
    gravity_tick_i = 1'b0;
    n_checks++;
    if (!ok || n != 21) begin
      n_bad++; $display("FAIL lock_latency got ok=%b cycles=%0d want ok=1 cycles=21", ok, n);
    end
    n_checks++;
    if (lines_clr_o !== 3'd0 || piece_req_o !== 1'b1 || lines_total_o !== 16'd0) begin
      n_bad++; $display("FAIL lock_result got clr=%0d req=%b tot=%0d want clr=0 req=1 tot=0",
                        lines_clr_o, piece_req_o, lines_total_o);
    end
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL lock_merge got=%h want=%h", display_o, e);
    end
    tick();
    n_checks++;
    if (lines_clr_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL valid_pulse_width got=%b want=0", lines_clr_valid_o);
    end
  endtask

  task automatic test_wall_priority();
    grid_t e;
    restart();
    give_piece(3'd0);
    e = '0;
    for (int r = 0; r < 4; r++) e[r][4] = 1;
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL i_spawn got=%h want=%h", display_o, e);
    end
    strobe(1, 1, 0, 0, 0);
    e = '0;
    for (int r = 1; r < 5; r++) e[r][4] = 1;
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL tick_over_left got=%h want=%h", display_o, e);
    end
    for (int k = 0; k < 5; k++) strobe(0, 1, 0, 0, 0);
    e = '0;
    for (int r = 1; r < 5; r++) e[r][9] = 1;
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL left_to_wall got=%h want=%h", display_o, e);
    end
    strobe(0, 1, 0, 0, 0);
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL left_past_wall got=%h want=%h", display_o, e);
    end
    strobe(0, 0, 0, 1, 0);
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL rotate_at_wall got=%h want=%h", display_o, e);
    end
    strobe(0, 0, 1, 0, 0);
    e = '0;
    for (int r = 1; r < 5; r++) e[r][8] = 1;
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL right_move got=%h want=%h", display_o, e);
    end
  endtask

  task automatic test_rotation();
    grid_t e;
    restart();
    give_piece(3'd0);
    strobe(0, 0, 0, 1, 0);
    e = '0;
    for (int b = 2; b < 6; b++) e[1][b] = 1;
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL rotate_once got=%h want=%h", display_o, e);
    end
    strobe(0, 0, 0, 1, 0);
    e = '0;
    for (int r = 0; r < 4; r++) e[r][3] = 1;
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL rotate_twice got=%h want=%h", display_o, e);
    end
  endtask

  task automatic test_line_clear();
    grid_t e;
    bit ok;
    int n;
    restart();
    for (int p = 0; p < 10; p++) begin
      wait_req(ok);
      n_checks++;
      if (!ok) begin
        n_bad++; $display("FAIL clear_req_timeout got req=%b want=1 piece=%0d", piece_req_o, p);
      end
      if (p == 9) begin
        e = '0;
        for (int r = 16; r < 20; r++) e[r] = 10'h1FF;
        n_checks++;
        if (display_o !== e) begin
          n_bad++; $display("FAIL nine_columns got=%h want=%h", display_o, e);
        end
      end
      give_piece(3'd0);
      if (p > 4) for (int k = 0; k < p - 4; k++) strobe(0, 1, 0, 0, 0);
      if (p < 4) for (int k = 0; k < 4 - p; k++) strobe(0, 0, 1, 0, 0);
      strobe(0, 0, 0, 0, 1);
      if (p == 0) begin
        for (int k = 0; k < 16; k++) tick();
        e = '0;
        for (int r = 16; r < 20; r++) e[r][0] = 1;
        n_checks++;
        if (display_o !== e) begin
          n_bad++; $display("FAIL drop_bottom got=%h want=%h", display_o, e);
        end
        tick();
        n_checks++;
        if (display_o !== '0) begin
          n_bad++; $display("FAIL lock_hides_piece got=%h want=0", display_o);
        end
      end
    end
    wait_valid(ok, n);
    n_checks++;
    if (!ok || lines_clr_o !== 3'd4 || lines_total_o !== 16'd4) begin
      n_bad++; $display("FAIL four_lines got ok=%b clr=%0d tot=%0d want ok=1 clr=4 tot=4",
                        ok, lines_clr_o, lines_total_o);
    end
    n_checks++;
    if (display_o !== '0) begin
      n_bad++; $display("FAIL cleared_grid got=%h want=0", display_o);
    end
  endtask

  task automatic test_game_over();
    grid_t e;
    bit ok;
    for (int p = 0; p < 11; p++) begin
      wait_req(ok);
      n_checks++;
      if (!ok) begin
        n_bad++; $display("FAIL stack_req_timeout got req=%b want=1 piece=%0d", piece_req_o, p);
      end
      give_piece(3'd1);
      if (p < 10) strobe(0, 0, 0, 0, 1);
    end
    n_checks++;
    if (game_over_o !== 1'b1 || piece_req_o !== 1'b0) begin
      n_bad++; $display("FAIL game_over got go=%b req=%b want go=1 req=0",
                        game_over_o, piece_req_o);
    end
    for (int r = 0; r < ROWS; r++) e[r] = 10'h030;
    n_checks++;
    if (display_o !== e) begin
      n_bad++; $display("FAIL stacked_grid got=%h want=%h", display_o, e);
    end
    pulse_start();
    n_checks++;
    if (display_o !== '0 || lines_total_o !== 16'd0 || piece_req_o !== 1'b1 ||
        game_over_o !== 1'b0) begin
      n_bad++; $display("FAIL restart got disp=%h tot=%0d req=%b go=%b want 0 0 1 0",
                        display_o, lines_total_o, piece_req_o, game_over_o);
    end
  endtask

  task automatic test_reset_mid_drop();
    give_piece(3'd0);
    strobe(0, 0, 0, 0, 1);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (display_o !== '0 || piece_req_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_drop got disp=%h req=%b want 0 0", display_o, piece_req_o);
    end
    pulse_start();
    n_checks++;
    if (display_o !== '0 || piece_req_o !== 1'b1) begin
      n_bad++; $display("FAIL start_after_abort got disp=%h req=%b want 0 1",
                        display_o, piece_req_o);
    end
  endtask

  initial begin
    test_reset();
    test_gravity_lock();
    test_wall_priority();
    test_rotation();
    test_line_clear();
    test_game_over();
    test_reset_mid_drop();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
